// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side master for a FIFO with registered d_out (one-cycle read latency). Prefetches up to
//   two words into a small output buffer and presents them as a valid/ready stream, so the stream
//   sustains one word per clock under back-pressure.
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   fifo_empty        FIFO empty flag
//   fifo_r_en         FIFO read strobe (FIFO pops on this edge)
//   fifo_d_out        FIFO read data, valid the cycle after an accepted fifo_r_en
//   flush             synchronous discard of buffered and in-flight words
//   m_valid/m_ready   stream handshake; m_data is the buffer head
//   words_read        count of words delivered on the stream, wraps modulo 2^COUNT_W
module fifo_stream_reader #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fifo_empty,
  output logic               fifo_r_en,
  input  logic [DATA_W-1:0]  fifo_d_out,
  input  logic               flush,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic [COUNT_W-1:0] words_read
);

  logic [DATA_W-1:0]  buf0_q, buf0_d;
  logic [DATA_W-1:0]  buf1_q, buf1_d;
  logic [1:0]         count_q, count_d;
  logic               inflight_q, inflight_d;
  logic [COUNT_W-1:0] words_read_q, words_read_d;

  logic       pop;
  logic [2:0] fill;  // buffered words plus the one in flight
  logic [2:0] occ;   // occupancy after this cycle's pop

  always_comb begin
    m_valid = !reset && (count_q != 2'd0);
    m_data  = m_valid ? buf0_q : '0;
    pop     = m_valid && m_ready;
    fill    = {1'b0, count_q} + {2'b00, inflight_q};
    // pop implies count_q >= 1, so this never underflows
    occ     = fill - {2'b00, pop};
    fifo_r_en = !reset && !flush && !fifo_empty && (occ < 3'd2);
  end

  always_comb begin
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    count_d      = count_q;
    inflight_d   = fifo_r_en;
    words_read_d = words_read_q + COUNT_W'(pop);
    if (flush) begin
      // Word arriving this cycle (if any) is dropped; fifo_r_en is low so nothing follows it.
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (inflight_q) begin
            buf0_d  = fifo_d_out;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (inflight_q && !pop) begin
            buf1_d  = fifo_d_out;
            count_d = 2'd2;
          end else if (inflight_q && pop) begin
            buf0_d  = fifo_d_out;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            buf0_d  = buf1_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf0_q       <= '0;
      buf1_q       <= '0;
      count_q      <= 2'd0;
      inflight_q   <= 1'b0;
      words_read_q <= '0;
    end else begin
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      words_read_q <= words_read_d;
    end
  end

  assign words_read = words_read_q;

  // Issue rule guarantees there is always a free slot for an in-flight word.
  a_no_overfill: assert property (@(posedge clk) disable iff (reset) fill <= 3'd2);

endmodule
